// File: rtl/scl_gen.sv
// Open-drain SCL generator with clock stretching.
// Timing scales with the master clock frequency (4F cycles per SCL period).
module scl_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] f_MHz,
    input  logic       go,
    input  logic       stop_cond,
    inout  wire        scl_m,
    output logic [5:0] contador,
    output logic [5:0] canvi,
    output logic [5:0] final_,
    output logic       start,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] canvi_q, canvi_d;
    logic [5:0] final_q, final_d;
    logic [3:0] f_q, f_d;

    logic [3:0] f_eff;
    logic [5:0] f6;
    logic [5:0] half;
    logic [5:0] per;
    logic       scl_low;
    logic       stall;

    always_comb begin
        if (f_MHz == 4'd0)
            f_eff = 4'd1;
        else if (f_MHz > 4'd12)
            f_eff = 4'd12;
        else
            f_eff = f_MHz;
    end

    // Timing uses the factor frozen on the last IDLE cycle.
    assign f6   = {2'b00, f_eff};
    assign half = {1'b0, f_q, 1'b0};
    assign per  = {f_q, 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            canvi_q <= 6'd0;
            final_q <= 6'd0;
            f_q     <= 4'd1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            canvi_q <= canvi_d;
            final_q <= final_d;
            f_q     <= f_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        canvi_d = canvi_q;
        final_d = final_q;
        f_d     = f_q;
        case (state_q)
            IDLE: begin
                cnt_d   = 6'd0;
                f_d     = f_eff;
                canvi_d = f6 + {f6[4:0], 1'b0};
                final_d = {f6[3:0], 2'b00} + f6 - 6'd1;
                if (go)
                    state_d = START;
            end
            START: begin
                if (!stall) begin
                    if (cnt_q == half - 6'd1)
                        state_d = RUN;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            RUN: begin
                if (stop_cond) begin
                    state_d = STOP;
                    cnt_d   = 6'd0;
                end else if (!stall) begin
                    if (cnt_q == per - 6'd1)
                        cnt_d = 6'd0;
                    else
                        cnt_d = cnt_q + 6'd1;
                end
            end
            STOP: begin
                if (cnt_q == per - 6'd1) begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_comb begin
        scl_low = 1'b0;
        stall   = 1'b0;
        if (state_q == START || state_q == RUN) begin
            scl_low = (cnt_q >= half);
            // A slave holding the released line low stretches the clock.
            stall   = !scl_low && (scl_m == 1'b0);
        end
    end

    assign scl_m    = scl_low ? 1'b0 : 1'bz;
    assign contador = cnt_q;
    assign canvi    = canvi_q;
    assign final_   = final_q;
    assign start    = (state_q == START);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_scl_gen.sv
// Directed bench for scl_gen: reset, timing for several factors,
// clock stretching, stop handling and asynchronous reset mid-transfer.
module tb_scl_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] f_MHz = 4'd2;
    logic       go = 1'b0;
    logic       stop_cond = 1'b0;
    logic       pull = 1'b0;
    wire        scl_m;
    logic [5:0] contador;
    logic [5:0] canvi;
    logic [5:0] final_;
    logic       start;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pullup (scl_m);
    assign scl_m = pull ? 1'b0 : 1'bz;

    scl_gen dut (
        .clk       (clk),
        .reset     (reset),
        .f_MHz     (f_MHz),
        .go        (go),
        .stop_cond (stop_cond),
        .scl_m     (scl_m),
        .contador  (contador),
        .canvi     (canvi),
        .final_    (final_),
        .start     (start),
        .busy      (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e;
        #2 reset = 1'b0;
        tick;
        tick;
        chk("rst_cnt", contador, 0);
        chk("rst_canvi", canvi, 0);
        chk("rst_final", final_, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_scl", scl_m, 1);

        reset = 1'b1;
        tick;
        chk("idle_canvi", canvi, 6);
        chk("idle_final", final_, 9);
        chk("idle_cnt", contador, 0);
        chk("idle_busy", busy, 0);
        chk("idle_scl", scl_m, 1);

        go = 1'b1;
        tick;
        go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("st_start", start, 1);
            chk("st_cnt", contador, i);
            chk("st_scl", scl_m, 1);
            if (i == 0)
                f_MHz = 4'd5;
            tick;
        end
        for (int k = 0; k < 16; k++) begin
            e = (4 + k) % 8;
            chk("run_cnt", contador, e);
            chk("run_scl", scl_m, (e < 4) ? 1 : 0);
            chk("run_start", start, 0);
            chk("run_canvi", canvi, 6);
            tick;
        end

        repeat (5) tick;
        chk("pre_str", contador, 1);
        pull = 1'b1;
        #1;
        chk("str_line", scl_m, 0);
        repeat (3) begin
            tick;
            chk("str_hold", contador, 1);
        end
        pull = 1'b0;
        tick;
        chk("str_resume", contador, 2);
        tick;
        chk("pre_stop", contador, 3);

        stop_cond = 1'b1;
        tick;
        stop_cond = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("stop_cnt", contador, i);
            chk("stop_scl", scl_m, 1);
            chk("stop_busy", busy, 1);
            tick;
        end
        chk("end_busy", busy, 0);
        chk("end_cnt", contador, 0);
        chk("end_canvi", canvi, 6);
        tick;
        chk("f5_canvi", canvi, 15);
        chk("f5_final", final_, 24);

        f_MHz = 4'd0;
        tick;
        chk("f0_canvi", canvi, 3);
        chk("f0_final", final_, 4);
        go = 1'b1;
        tick;
        for (int i = 0; i < 6; i++) begin
            chk("f0_cnt", contador, i % 4);
            chk("f0_scl", scl_m, ((i % 4) < 2) ? 1 : 0);
            chk("f0_start", start, (i < 2) ? 1 : 0);
            tick;
        end
        stop_cond = 1'b1;
        tick;
        stop_cond = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("f0_stop_busy", busy, 1);
            chk("f0_stop_cnt", contador, i);
            tick;
        end
        chk("go_idle_busy", busy, 0);
        chk("go_idle_start", start, 0);
        tick;
        chk("go_restart", start, 1);
        chk("go_restart_cnt", contador, 0);
        go = 1'b0;

        stop_cond = 1'b1;
        tick;
        stop_cond = 1'b0;
        chk("st_ign_start", start, 1);
        chk("st_ign_cnt", contador, 1);
        tick;
        chk("f0_run_start", start, 0);
        chk("f0_run_cnt", contador, 2);
        chk("f0_run_scl", scl_m, 0);
        stop_cond = 1'b1;
        tick;
        stop_cond = 1'b0;
        chk("f0_stop2_busy", busy, 1);
        chk("f0_stop2_cnt", contador, 0);
        repeat (4) tick;
        chk("f0_stop2_end", busy, 0);

        f_MHz = 4'd15;
        tick;
        chk("f15_canvi", canvi, 36);
        chk("f15_final", final_, 59);
        go = 1'b1;
        tick;
        go = 1'b0;
        repeat (23) tick;
        chk("f15_st_cnt", contador, 23);
        chk("f15_st_start", start, 1);
        chk("f15_st_scl", scl_m, 1);
        tick;
        chk("f15_run_start", start, 0);
        chk("f15_run_cnt", contador, 24);
        chk("f15_run_scl", scl_m, 0);
        repeat (23) tick;
        chk("f15_last_cnt", contador, 47);
        chk("f15_last_scl", scl_m, 0);
        tick;
        chk("f15_wrap_cnt", contador, 0);
        chk("f15_wrap_scl", scl_m, 1);
        stop_cond = 1'b1;
        tick;
        stop_cond = 1'b0;
        repeat (47) tick;
        chk("f15_stop_busy", busy, 1);
        chk("f15_stop_cnt", contador, 47);
        tick;
        chk("f15_stop_end", busy, 0);

        f_MHz = 4'd2;
        tick;
        go = 1'b1;
        tick;
        go = 1'b0;
        repeat (5) tick;
        chk("mid_cnt", contador, 5);
        chk("mid_scl", scl_m, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_cnt", contador, 0);
        chk("arst_canvi", canvi, 0);
        chk("arst_final", final_, 0);
        chk("arst_start", start, 0);
        chk("arst_busy", busy, 0);
        chk("arst_scl", scl_m, 1);
        tick;
        reset = 1'b1;
        tick;
        chk("post_canvi", canvi, 6);
        chk("post_final", final_, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
